pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RV32I core. It arbitrates the per-stage hold, flush and PC-redirect controls between four requesters: the data-memory wait, the execute-stage jump, the execute-stage multi-cycle hold, and the ID-stage load-use hazard. It tracks hold episodes with a small state machine and a watchdog counter. It sits beside the pipeline registers, taking `jump_en`/`jump_addr`/`hold_flag` from the execute stage and driving the PC, IF/ID, ID/EX and EX/MEM register controls.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_hazard_detect.sv | 20 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Holds the FSM state encoding, the bubble instruction and the control bundle struct.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_RUN      = 2'd0,
    PIPE_ST_MEM_WAIT = 2'd1,
    PIPE_ST_EX_HOLD  = 2'd2
  } pipe_st_e;

  // addi x0, x0, 0 -- what a flushed register presents downstream
  localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic redirect_en;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
// Purely combinational; x0 never creates a hazard.
module hazard_detect (
  input  logic       ex_mem_re_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_re_i,
  input  logic       id_rs2_re_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit    = id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign load_use_o = ex_mem_re_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/redirect arbiter: controls are zero-latency, watchdog pulse is registered.
// Holds are the backpressure; mem_busy outranks everything. Stats counters need PIPE_CTRL_STATS_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        mem_busy_i,
  input  logic        ex_mem_re_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        ex_mem_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        redirect_en_o,
  output logic [31:0] redirect_addr_o,
  output logic        hold_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_TOP  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  pipe_st_e      state_q;
  logic [CW-1:0] hold_cnt_q;
  logic          hold_timeout_q;
  logic          load_use;
  logic          mem_win;
  logic          ex_win;
  pipe_ctl_t     ctl;
  logic [31:0]   redirect_addr;

  hazard_detect u_hazard_detect (
    .ex_mem_re_i   (ex_mem_re_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_re_i   (id_rs1_re_i),
    .id_rs2_re_i   (id_rs2_re_i),
    .load_use_o    (load_use)
  );

  // Rows are evaluated top-down; a lower row never contributes once a higher one matches.
  always_comb begin
    ctl           = '0;
    redirect_addr = '0;
    mem_win       = 1'b0;
    ex_win        = 1'b0;
    if (!rst_n) begin
      ctl = '0;
    end else if (mem_busy_i) begin
      mem_win         = 1'b1;
      ctl.pc_hold     = 1'b1;
      ctl.if_id_hold  = 1'b1;
      ctl.id_ex_hold  = 1'b1;
      ctl.ex_mem_hold = 1'b1;
    end else if (jump_en_i) begin
      ctl.redirect_en = 1'b1;
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      redirect_addr   = jump_addr_i;
    end else if (hold_flag_i) begin
      ex_win           = 1'b1;
      ctl.pc_hold      = 1'b1;
      ctl.if_id_hold   = 1'b1;
      ctl.id_ex_hold   = 1'b1;
      ctl.ex_mem_flush = 1'b1;
    end else if (load_use) begin
      ctl.pc_hold     = 1'b1;
      ctl.if_id_hold  = 1'b1;
      ctl.id_ex_flush = 1'b1;
    end
  end

  // The counter only continues an episode already in EX_HOLD; entering the state restarts it at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= PIPE_ST_RUN;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      hold_timeout_q <= ex_win && (hold_cnt_q == HOLD_LAST);
      if (mem_win) begin
        state_q    <= PIPE_ST_MEM_WAIT;
        hold_cnt_q <= '0;
      end else if (ex_win) begin
        state_q <= PIPE_ST_EX_HOLD;
        if (state_q != PIPE_ST_EX_HOLD) begin
          hold_cnt_q <= CW'(1);
        end else if (hold_cnt_q != HOLD_TOP) begin
          hold_cnt_q <= hold_cnt_q + CW'(1);
        end
      end else begin
        state_q    <= PIPE_ST_RUN;
        hold_cnt_q <= '0;
      end
    end
  end

  assign pc_hold_o       = ctl.pc_hold;
  assign if_id_hold_o    = ctl.if_id_hold;
  assign id_ex_hold_o    = ctl.id_ex_hold;
  assign ex_mem_hold_o   = ctl.ex_mem_hold;
  assign if_id_flush_o   = ctl.if_id_flush;
  assign id_ex_flush_o   = ctl.id_ex_flush;
  assign ex_mem_flush_o  = ctl.ex_mem_flush;
  assign redirect_en_o   = ctl.redirect_en;
  assign redirect_addr_o = redirect_addr;
  assign hold_timeout_o  = hold_timeout_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (ctl.pc_hold)     stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (ctl.redirect_en) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  assign stall_cnt_o    = '0;
  assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with HOLD_MAX=4; stats expectations follow PIPE_CTRL_STATS_EN.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        mem_busy_i;
  logic        ex_mem_re_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic        pc_hold_o;
  logic        if_id_hold_o;
  logic        id_ex_hold_o;
  logic        ex_mem_hold_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        ex_mem_flush_o;
  logic        redirect_en_o;
  logic [31:0] redirect_addr_o;
  logic        hold_timeout_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] redirect_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, ex_mem_flush, redirect_en}
  logic [7:0] ctl;
  localparam logic [7:0] CTL_NONE     = 8'b0000_0000;
  localparam logic [7:0] CTL_LOAD_USE = 8'b1100_0100;
  localparam logic [7:0] CTL_JUMP     = 8'b0000_1101;
  localparam logic [7:0] CTL_MEM      = 8'b1111_0000;
  localparam logic [7:0] CTL_EX_HOLD  = 8'b1110_0010;

  assign ctl = {pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o,
                if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, redirect_en_o};

  always #5 clk = ~clk;

  pipe_ctrl #(.HOLD_MAX(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .jump_en_i       (jump_en_i),
    .jump_addr_i     (jump_addr_i),
    .hold_flag_i     (hold_flag_i),
    .mem_busy_i      (mem_busy_i),
    .ex_mem_re_i     (ex_mem_re_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs1_re_i     (id_rs1_re_i),
    .id_rs2_re_i     (id_rs2_re_i),
    .pc_hold_o       (pc_hold_o),
    .if_id_hold_o    (if_id_hold_o),
    .id_ex_hold_o    (id_ex_hold_o),
    .ex_mem_hold_o   (ex_mem_hold_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .ex_mem_flush_o  (ex_mem_flush_o),
    .redirect_en_o   (redirect_en_o),
    .redirect_addr_o (redirect_addr_o),
    .hold_timeout_o  (hold_timeout_o),
    .stall_cnt_o     (stall_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o)
  );

  // Each cycle: inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jump_en_i     = 1'b0;
    jump_addr_i   = 32'h0;
    hold_flag_i   = 1'b0;
    mem_busy_i    = 1'b0;
    ex_mem_re_i   = 1'b0;
    ex_rd_addr_i  = 5'd0;
    id_rs1_addr_i = 5'd0;
    id_rs2_addr_i = 5'd0;
    id_rs1_re_i   = 1'b0;
    id_rs2_re_i   = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic re1, input logic re2);
    ex_mem_re_i   = 1'b1;
    ex_rd_addr_i  = rd;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_rs1_re_i   = re1;
    id_rs2_re_i   = re2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_busy_i = 1'b1;
    jump_en_i  = 1'b1;
    jump_addr_i = 32'hDEAD_BEEF;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    n_checks++;
    if (redirect_addr_o !== 32'h0) begin
      $display("FAIL reset_addr: got %h expected 0", redirect_addr_o); n_fail++;
    end
    n_checks++;
    if (hold_timeout_o !== 1'b0) begin
      $display("FAIL reset_timeout: got %b expected 0", hold_timeout_o); n_fail++;
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0 || redirect_cnt_o !== 32'd0) begin
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cnt_o, redirect_cnt_o); n_fail++;
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_load_use();
    next_cycle();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_LOAD_USE) begin
      $display("FAIL load_use_rs1: got %b expected %b", ctl, CTL_LOAD_USE); n_fail++;
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL load_use_bubble: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    next_cycle();
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL load_use_x0: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    next_cycle();
    set_load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_LOAD_USE) begin
      $display("FAIL load_use_rs2: got %b expected %b", ctl, CTL_LOAD_USE); n_fail++;
    end
    next_cycle();
    set_load_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL load_use_rs2_unread: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    next_cycle();
    set_load_use(5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    ex_mem_re_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL load_use_not_load: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_jump();
    next_cycle();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h0000_0100;
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_JUMP || redirect_addr_o !== 32'h0000_0100) begin
      $display("FAIL jump_over_load_use: got %b/%h expected %b/%h", ctl, redirect_addr_o,
               CTL_JUMP, 32'h0000_0100); n_fail++;
    end
    next_cycle();
    idle_inputs();
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h8000_0ABC;
    hold_flag_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_JUMP || redirect_addr_o !== 32'h8000_0ABC) begin
      $display("FAIL jump_over_hold: got %b/%h expected %b/%h", ctl, redirect_addr_o,
               CTL_JUMP, 32'h8000_0ABC); n_fail++;
    end
    next_cycle();
    idle_inputs();
    jump_addr_i = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE || redirect_addr_o !== 32'h0) begin
      $display("FAIL jump_idle_addr: got %b/%h expected %b/0", ctl, redirect_addr_o, CTL_NONE);
      n_fail++;
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      mem_busy_i  = 1'b1;
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_0200;
      hold_flag_i = (i == 2);
      @(negedge clk);
      n_checks++;
      if (ctl !== CTL_MEM || redirect_addr_o !== 32'h0) begin
        $display("FAIL mem_wait_cycle%0d: got %b/%h expected %b/0", i + 1, ctl, redirect_addr_o,
                 CTL_MEM); n_fail++;
      end
    end
    next_cycle();
    mem_busy_i  = 1'b0;
    hold_flag_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_JUMP || redirect_addr_o !== 32'h0000_0200) begin
      $display("FAIL mem_wait_release: got %b/%h expected %b/%h", ctl, redirect_addr_o,
               CTL_JUMP, 32'h0000_0200); n_fail++;
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      idle_inputs();
      hold_flag_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ctl !== CTL_EX_HOLD || hold_timeout_o !== (i == 4)) begin
        $display("FAIL watchdog_cycle%0d: got %b/%b expected %b/%b", i + 1, ctl, hold_timeout_o,
                 CTL_EX_HOLD, (i == 4)); n_fail++;
      end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE || hold_timeout_o !== 1'b0) begin
      $display("FAIL watchdog_after: got %b/%b expected %b/0", ctl, hold_timeout_o, CTL_NONE);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      hold_flag_i = 1'b1;
    end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE) begin
      $display("FAIL reset_mid_hold_ctl: got %b expected %b", ctl, CTL_NONE); n_fail++;
    end
    next_cycle();
    rst_n       = 1'b1;
    hold_flag_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl !== CTL_NONE || hold_timeout_o !== 1'b0) begin
      $display("FAIL reset_mid_hold_pending: got %b/%b expected %b/0", ctl, hold_timeout_o,
               CTL_NONE); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      hold_flag_i = (i < 4);
      @(negedge clk);
      n_checks++;
      if (hold_timeout_o !== (i == 4)) begin
        $display("FAIL fresh_hold_cycle%0d: got %b expected %b", i + 1, hold_timeout_o, (i == 4));
        n_fail++;
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_stats();
    logic [31:0] exp_stall;
    logic [31:0] exp_redir;
`ifdef PIPE_CTRL_STATS_EN
    exp_stall = 32'd2;
    exp_redir = 32'd3;
`else
    exp_stall = 32'd0;
    exp_redir = 32'd0;
`endif
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_load_use(5'd12, 5'd0, 5'd12, 1'b0, 1'b1);
      next_cycle();
      idle_inputs();
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_1000 + 32'(i * 4);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (stall_cnt_o !== exp_stall) begin
      $display("FAIL stats_stall: got %0d expected %0d", stall_cnt_o, exp_stall); n_fail++;
    end
    n_checks++;
    if (redirect_cnt_o !== exp_redir) begin
      $display("FAIL stats_redirect: got %0d expected %0d", redirect_cnt_o, exp_redir); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_hold();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
